// File: rtl/embox_pkg.sv
// Shared definitions for the mailbox drainer: FSM state encoding and the
// default EMBOXLO/EMBOXHI byte addresses used by the embox register map.
package embox_pkg;

  localparam int unsigned EMBOX_DW = 32;
  localparam int unsigned EMBOX_AW = 20;

  localparam logic [EMBOX_AW-1:0] EMBOXLO_ADDR = 20'h00000;
  localparam logic [EMBOX_AW-1:0] EMBOXHI_ADDR = 20'h00004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    CAP   = 3'd3,
    HOLD  = 3'd4
  } drain_state_e;

  // The drainer owns the mi bus only while issuing its two reads.
  function automatic logic drainer_owns_bus(input drain_state_e s);
    return (s == RD_LO) || (s == RD_HI);
  endfunction

endpackage

// File: rtl/embox_mi_arb.sv
// Combinational mi bus mux between the host register path and the drainer,
// plus the host stall indication while the drainer owns the bus.
module embox_mi_arb
  import embox_pkg::*;
#(
  parameter int unsigned     DW      = EMBOX_DW,
  parameter int unsigned     AW      = EMBOX_AW,
  parameter logic [AW-1:0]   LO_ADDR = AW'(EMBOXLO_ADDR),
  parameter logic [AW-1:0]   HI_ADDR = AW'(EMBOXHI_ADDR)
) (
  input  drain_state_e       state_i,
  input  logic               host_en_i,
  input  logic               host_we_i,
  input  logic [AW-1:0]      host_addr_i,
  input  logic [DW-1:0]      host_din_i,
  output logic               mi_en_o,
  output logic               mi_we_o,
  output logic [AW-1:0]      mi_addr_o,
  output logic [DW-1:0]      mi_din_o,
  output logic               host_wait_o
);

  logic drv_active;

  assign drv_active = drainer_owns_bus(state_i);

  always_comb begin
    // NOTE: every output gets a default before the override, so no path leaves one unassigned and no latch is inferred.
    mi_en_o   = host_en_i;
    mi_we_o   = host_we_i;
    mi_addr_o = host_addr_i;
    mi_din_o  = host_din_i;
    if (drv_active) begin
      mi_en_o   = 1'b1;
      mi_we_o   = 1'b0;
      mi_addr_o = (state_i == RD_HI) ? HI_ADDR : LO_ADDR;
      mi_din_o  = '0;
    end
  end

  // A stalled host request is not forwarded; the host must hold it.
  assign host_wait_o = host_en_i & drv_active;

endmodule

// File: rtl/embox_drain.sv
// Mailbox drainer: reads each 64-bit embox entry (LO, then HI which pops) and
// presents it on a valid/ready message port while sharing the mi bus with the host.
module embox_drain
  import embox_pkg::*;
#(
  parameter int unsigned     DW      = EMBOX_DW,
  parameter int unsigned     AW      = EMBOX_AW,
  parameter logic [AW-1:0]   LO_ADDR = AW'(EMBOXLO_ADDR),
  parameter logic [AW-1:0]   HI_ADDR = AW'(EMBOXHI_ADDR),
  parameter int unsigned     CW      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               drain_en,
  input  logic               embox_not_empty,
  output logic               mi_en,
  output logic               mi_we,
  output logic [AW-1:0]      mi_addr,
  output logic [DW-1:0]      mi_din,
  input  logic [DW-1:0]      mi_dout,
  input  logic               host_mi_en,
  input  logic               host_mi_we,
  input  logic [AW-1:0]      host_mi_addr,
  input  logic [DW-1:0]      host_mi_din,
  output logic [DW-1:0]      host_mi_dout,
  output logic               host_wait,
  output logic [2*DW-1:0]    msg_data,
  output logic               msg_valid,
  input  logic               msg_ready,
  output logic [CW-1:0]      msg_count
);

  drain_state_e      state_q;
  logic [DW-1:0]     lo_q;
  logic [2*DW-1:0]   msg_data_q;
  logic              msg_valid_q;
  logic [CW-1:0]     msg_count_q;
  logic              host_en_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      msg_data_q  <= '0;
      msg_valid_q <= 1'b0;
      msg_count_q <= '0;
      host_en_q   <= 1'b0;
    end else begin
      host_en_q <= host_mi_en;
      unique case (state_q)
        IDLE: begin
          // host_en_q masks the stale not_empty in the cycle after a host pop.
          if (drain_en && embox_not_empty && !host_mi_en && !host_en_q) begin
            state_q <= RD_LO;
          end
        end
        RD_LO: state_q <= RD_HI;
        RD_HI: begin
          lo_q    <= mi_dout;
          state_q <= CAP;
        end
        CAP: begin
          msg_data_q  <= {mi_dout, lo_q};
          msg_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (msg_valid_q && msg_ready) begin
            msg_valid_q <= 1'b0;
            msg_count_q <= msg_count_q + CW'(1);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  embox_mi_arb #(
    .DW      (DW),
    .AW      (AW),
    .LO_ADDR (LO_ADDR),
    .HI_ADDR (HI_ADDR)
  ) u_arb (
    .state_i     (state_q),
    .host_en_i   (host_mi_en),
    .host_we_i   (host_mi_we),
    .host_addr_i (host_mi_addr),
    .host_din_i  (host_mi_din),
    .mi_en_o     (mi_en),
    .mi_we_o     (mi_we),
    .mi_addr_o   (mi_addr),
    .mi_din_o    (mi_din),
    .host_wait_o (host_wait)
  );

  assign host_mi_dout = mi_dout;
  assign msg_data     = msg_data_q;
  assign msg_valid    = msg_valid_q;
  assign msg_count    = msg_count_q;

endmodule
